// File: rtl/program_sequencer.sv
// Multi-cycle instruction sequencer: fetch / decode / execute control with conditional branches.
// Define SEQ_CALL_STACK_EN to add a CALL/RET return stack; otherwise CALL and RET behave as NOP.
module program_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int IMM_W       = 8,
  parameter int RESET_PC    = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        ALUFlags,
  output logic              instr_req,
  output logic [ADDR_W-1:0] InstrAddr,
  input  logic              instr_ack,
  input  logic [IMM_W+7:0]  instr_rdata,
  output logic              WE,
  output logic              ALUorM,
  output logic [2:0]        ALUCntr,
  output logic              ALUSrc2,
  output logic [1:0]        RDst3,
  output logic [1:0]        RSrc1,
  output logic [IMM_W-1:0]  Src2,
  output logic [2:0]        state,
  output logic              halted,
  output logic              stack_err
);

  localparam int INSTR_W = IMM_W + 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pcNext;
  logic [INSTR_W-1:0]  r_ir;
  logic [3:0]          r_flags;
  logic                w_loadIr;
  logic                w_captureFlags;

  logic [2:0]          w_opcode;
  logic [3:0]          w_cond;
  logic [IMM_W-1:0]    w_src2;
  logic [1:0]          w_flagIdx;
  logic                w_taken;
  logic [ADDR_W-1:0]   w_pcInc;
  logic [ADDR_W-1:0]   w_target;

  assign w_opcode = r_ir[INSTR_W-1 -: 3];
  assign w_cond   = r_ir[IMM_W+4:IMM_W+1];
  assign w_src2   = r_ir[IMM_W-1:0];
  assign w_pcInc  = r_pc + ADDR_W'(1);
  assign w_target = ADDR_W'(w_src2);

  // cond[1:0] names a flag in {N,Z,C,V} order, so 0 selects N (bit 3) and 3 selects V (bit 0).
  assign w_flagIdx = ~w_cond[1:0];
  assign w_taken   = w_cond[3] | (r_flags[w_flagIdx] ^ w_cond[2]);

`ifdef SEQ_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic              r_stackErr;
  logic              w_push;
  logic              w_pop;
  logic              w_fault;
  logic              w_stackFull;
  logic              w_stackEmpty;
  logic [IDX_W-1:0]  w_pushIdx;
  logic [IDX_W-1:0]  w_popIdx;
  logic [ADDR_W-1:0] w_popData;

  assign w_stackFull  = (r_sp == SP_W'(STACK_DEPTH));
  assign w_stackEmpty = (r_sp == '0);
  assign w_pushIdx    = IDX_W'(r_sp);
  assign w_popIdx     = IDX_W'(r_sp - SP_W'(1));
  assign w_popData    = r_stack[w_popIdx];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_pcNext       = r_pc;
    w_loadIr       = 1'b0;
    w_captureFlags = 1'b0;
`ifdef SEQ_CALL_STACK_EN
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_fault        = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_stateNext = S_FETCH;
          w_pcNext    = ADDR_W'(RESET_PC);
        end
      end
      S_FETCH: begin
        if (instr_ack) begin
          w_loadIr    = 1'b1;
          w_stateNext = S_DECODE;
        end
      end
      S_DECODE: w_stateNext = S_EXEC;
      S_EXEC: begin
        w_stateNext = S_FETCH;
        w_pcNext    = w_pcInc;
        case (w_opcode)
          3'b110: begin
            if (w_taken) w_pcNext = w_target;
          end
          3'b111: begin
            case (w_cond[1:0])
              2'b00: begin
                w_stateNext = S_HALT;
                w_pcNext    = r_pc;
              end
`ifdef SEQ_CALL_STACK_EN
              // A stack fault halts without touching the stack so the offending pc stays visible.
              2'b01: begin
                if (w_stackFull) begin
                  w_fault     = 1'b1;
                  w_stateNext = S_HALT;
                  w_pcNext    = r_pc;
                end else begin
                  w_push   = 1'b1;
                  w_pcNext = w_target;
                end
              end
              2'b10: begin
                if (w_stackEmpty) begin
                  w_fault     = 1'b1;
                  w_stateNext = S_HALT;
                  w_pcNext    = r_pc;
                end else begin
                  w_pop    = 1'b1;
                  w_pcNext = w_popData;
                end
              end
`endif
              default: ;
            endcase
          end
          3'b101: ;
          default: w_captureFlags = 1'b1;
        endcase
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= ADDR_W'(RESET_PC);
      r_ir    <= '0;
      r_flags <= 4'b0000;
    end else begin
      r_pc <= w_pcNext;
      if (w_loadIr) r_ir <= instr_rdata;
      if (w_captureFlags) r_flags <= ALUFlags;
    end
  end

`ifdef SEQ_CALL_STACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp       <= '0;
      r_stackErr <= 1'b0;
    end else begin
      if (w_push) begin
        r_sp <= r_sp + SP_W'(1);
      end else if (w_pop) begin
        r_sp <= r_sp - SP_W'(1);
      end
      if (w_fault) r_stackErr <= 1'b1;
    end
  end

  // Entries above the pointer are don't-care, so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_pushIdx] <= w_pcInc;
  end

  assign stack_err = r_stackErr;
`else
  assign stack_err = 1'b0;
`endif

  assign instr_req = (r_state == S_FETCH);
  assign InstrAddr = r_pc;
  assign WE        = (r_state == S_EXEC) && (w_opcode <= 3'b101);
  assign ALUorM    = (w_opcode == 3'b101);
  assign ALUCntr   = (w_opcode <= 3'b101) ? w_opcode : 3'b000;
  assign ALUSrc2   = r_ir[IMM_W];
  assign RDst3     = r_ir[IMM_W+4:IMM_W+3];
  assign RSrc1     = r_ir[IMM_W+2:IMM_W+1];
  assign Src2      = w_src2;
  assign state     = r_state;
  assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a memory responder serves fetches, a monitor checks
// fetch addresses and write-back controls against queued expectations. Honours SEQ_CALL_STACK_EN.
module tb_program_sequencer;

  localparam int ADDR_W  = 8;
  localparam int IMM_W   = 8;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         ALUFlags = 4'b0000;
  logic               instr_req;
  logic [ADDR_W-1:0]  InstrAddr;
  logic               instr_ack = 1'b0;
  logic [INSTR_W-1:0] instr_rdata = '0;
  logic               WE;
  logic               ALUorM;
  logic [2:0]         ALUCntr;
  logic               ALUSrc2;
  logic [1:0]         RDst3;
  logic [1:0]         RSrc1;
  logic [IMM_W-1:0]   Src2;
  logic [2:0]         state;
  logic               halted;
  logic               stack_err;

  program_sequencer #(
    .ADDR_W(ADDR_W), .IMM_W(IMM_W), .RESET_PC(0), .STACK_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ALUFlags(ALUFlags),
    .instr_req(instr_req), .InstrAddr(InstrAddr), .instr_ack(instr_ack),
    .instr_rdata(instr_rdata), .WE(WE), .ALUorM(ALUorM), .ALUCntr(ALUCntr),
    .ALUSrc2(ALUSrc2), .RDst3(RDst3), .RSrc1(RSrc1), .Src2(Src2),
    .state(state), .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ackDelay = 0;
  logic [ADDR_W-1:0]  expAddrQ[$];
  logic [5:0]         expWeQ[$];
  logic [INSTR_W-1:0] mem [256];

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, 1'b1, imm};
  endfunction

  function automatic logic [15:0] br(input logic [3:0] cond, input logic [7:0] tgt);
    return {3'b110, cond, 1'b0, tgt};
  endfunction

  function automatic logic [15:0] sys(input logic [1:0] sel, input logic [7:0] tgt);
    return {3'b111, 2'b00, sel, 1'b0, tgt};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every unused word is HALT, so a wrong fetch address shows up quickly.
  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = sys(2'b00, 8'h00);
  endtask

  task automatic doReset();
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_instr_req", instr_req, 0);
    checkOutput("rst_we", WE, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_stack_err", stack_err, 0);
    checkOutput("rst_pc", InstrAddr, 0);
    checkOutput("rst_ir", {RDst3, RSrc1, ALUSrc2, Src2}, 0);
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_first_edge", state, 1);
  endtask

  task automatic restart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_addr", InstrAddr, 0);
  endtask

  task automatic waitHalt(input string name);
    int n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, halted, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((expAddrQ.size() != 0 || expWeQ.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, expAddrQ.size() + expWeQ.size(), 0);
  endtask

  // Memory responder: acknowledges a fetch after ackDelay waiting cycles.
  initial begin
    int waitCnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (instr_req) begin
        if (waitCnt >= ackDelay) begin
          instr_ack   = 1'b1;
          instr_rdata = mem[InstrAddr];
        end else begin
          instr_ack = 1'b0;
          waitCnt++;
        end
      end else begin
        instr_ack = 1'b0;
        waitCnt   = 0;
      end
    end
  end

  // Monitor: every accepted fetch and every write-back pulse consumes one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && instr_req && instr_ack) begin
        if (expAddrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL fetch_unexpected: got 0x%0h, expected none", InstrAddr);
        end else begin
          checkOutput("fetch_addr", InstrAddr, expAddrQ.pop_front());
        end
      end
      if (reset && WE) begin
        if (expWeQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL we_unexpected: got 0x%0h, expected none", {ALUorM, ALUCntr, RDst3});
        end else begin
          checkOutput("writeback", {ALUorM, ALUCntr, RDst3}, expWeQ.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int reqCyc;
    int n;
    int bad;

    // ALU, taken/not-taken branches, load, NOP, HALT at 0x05, then restart.
    clearMem();
    mem[8'h00] = alu(3'b000, 2'd1, 2'd2, 8'h5A);
    mem[8'h01] = br(4'b0001, 8'h40);
    mem[8'h40] = br(4'b0101, 8'h80);
    mem[8'h41] = {3'b101, 2'd3, 2'd0, 1'b0, 8'h10};
    mem[8'h42] = br(4'b1000, 8'h03);
    mem[8'h03] = sys(2'b11, 8'h00);
    mem[8'h04] = alu(3'b011, 2'd2, 2'd1, 8'h00);
    mem[8'h05] = sys(2'b00, 8'h00);
    ALUFlags = 4'b0100;
    ackDelay = 3;
    for (int pass = 0; pass < 2; pass++) begin
      expAddrQ.push_back(8'h00); expAddrQ.push_back(8'h01); expAddrQ.push_back(8'h40);
      expAddrQ.push_back(8'h41); expAddrQ.push_back(8'h42); expAddrQ.push_back(8'h03);
      expAddrQ.push_back(8'h04); expAddrQ.push_back(8'h05);
      expWeQ.push_back(6'b000001); expWeQ.push_back(6'b110111); expWeQ.push_back(6'b001110);
    end
    doReset();
    applyStimulus();
    reqCyc = 0;
    n = 0;
    while (n < 50) begin
      if (instr_req) reqCyc++;
      if (instr_req && instr_ack) break;
      @(negedge clk);
      n++;
    end
    checkOutput("req_cycles", reqCyc, 4);
    @(negedge clk);
    checkOutput("decode_state", state, 2);
    checkOutput("decode_we", WE, 0);
    checkOutput("decode_fields", {RDst3, RSrc1, ALUSrc2, Src2}, {2'd1, 2'd2, 1'b1, 8'h5A});
    checkOutput("decode_alucntr", ALUCntr, 0);
    @(negedge clk);
    checkOutput("exec_state", state, 3);
    checkOutput("exec_we", WE, 1);
    waitHalt("halt_at_5");
    checkOutput("halt_pc", InstrAddr, 8'h05);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!halted || instr_req) bad++;
    end
    checkOutput("halt_hold", bad, 0);
    restart();
    waitHalt("halt_again");
    drain("scn1_drain");

    // Not-taken on clear flag, pc wrap 0xFF -> 0x00, flag capture makes the retry taken.
    clearMem();
    mem[8'h00] = br(4'b0001, 8'h20);
    mem[8'h01] = br(4'b1000, 8'hFF);
    mem[8'hFF] = alu(3'b001, 2'd0, 2'd0, 8'h00);
    ALUFlags = 4'b0100;
    ackDelay = 0;
    expAddrQ.push_back(8'h00); expAddrQ.push_back(8'h01); expAddrQ.push_back(8'hFF);
    expAddrQ.push_back(8'h00); expAddrQ.push_back(8'h20);
    expWeQ.push_back(6'b000100);
    doReset();
    applyStimulus();
    waitHalt("halt_at_20");
    checkOutput("wrap_halt_pc", InstrAddr, 8'h20);
    drain("scn2_drain");

    // Asynchronous reset while a fetch is outstanding.
    clearMem();
    ackDelay = 10;
    doReset();
    applyStimulus();
    @(negedge clk);
    checkOutput("midfetch_req", instr_req, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_req", instr_req, 0);
    checkOutput("async_state", state, 0);
    ackDelay = 0;

    // CALL then RET, then RET on the (now) empty stack.
    clearMem();
    mem[8'h00] = sys(2'b01, 8'h10);
    mem[8'h01] = sys(2'b10, 8'h00);
    mem[8'h02] = sys(2'b00, 8'h00);
    mem[8'h10] = sys(2'b10, 8'h00);
`ifdef SEQ_CALL_STACK_EN
    expAddrQ.push_back(8'h00); expAddrQ.push_back(8'h10); expAddrQ.push_back(8'h01);
`else
    expAddrQ.push_back(8'h00); expAddrQ.push_back(8'h01); expAddrQ.push_back(8'h02);
`endif
    doReset();
    applyStimulus();
    waitHalt("callret_halt");
`ifdef SEQ_CALL_STACK_EN
    checkOutput("ret_empty_err", stack_err, 1);
    checkOutput("ret_empty_pc", InstrAddr, 8'h01);
`else
    checkOutput("nostack_err", stack_err, 0);
    checkOutput("nostack_pc", InstrAddr, 8'h02);
`endif
    drain("scn4_drain");

`ifdef SEQ_CALL_STACK_EN
    // Five nested CALLs overflow a four-entry stack.
    clearMem();
    mem[8'h00] = sys(2'b01, 8'h10);
    mem[8'h10] = sys(2'b01, 8'h20);
    mem[8'h20] = sys(2'b01, 8'h30);
    mem[8'h30] = sys(2'b01, 8'h50);
    mem[8'h50] = sys(2'b01, 8'h60);
    expAddrQ.push_back(8'h00); expAddrQ.push_back(8'h10); expAddrQ.push_back(8'h20);
    expAddrQ.push_back(8'h30); expAddrQ.push_back(8'h50);
    doReset();
    applyStimulus();
    waitHalt("overflow_halt");
    checkOutput("overflow_err", stack_err, 1);
    checkOutput("overflow_pc", InstrAddr, 8'h50);
    expAddrQ.push_back(8'h00);
    restart();
    waitHalt("overflow_again");
    checkOutput("err_sticky", stack_err, 1);
    drain("scn5_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
- REQ-001: Parameters SHALL be, one per line (name, default, meaning):
  - ADDR_W, 8, program-counter/instruction-address width.
  - IMM_W, 8, immediate (Src2) width; instruction width INSTR_W = IMM_W+8.
  - RESET_PC, 0, first fetch address after start.
  - STACK_DEPTH, 4, return-stack entries (used only with SEQ_CALL_STACK_EN).
- REQ-002: One clock; reset is asynchronous and active-low. Ports, clock and reset first (name, direction, width, meaning):
  - clk, in, 1, clock.
  - reset, in, 1, async active-low reset.
  - start, in, 1, begin execution.
  - ALUFlags, in, 4, {N,Z,C,V} from datapath.
  - instr_req, out, 1, fetch request.
  - InstrAddr, out, ADDR_W, fetch address.
  - instr_ack, in, 1, fetch data valid.
  - instr_rdata, in, INSTR_W, fetched word.
  - WE, out, 1, register write enable.
  - ALUorM, out, 1, writeback select (1 = memory).
  - ALUCntr, out, 3, ALU operation.
  - ALUSrc2, out, 1, immediate select.
  - RDst3, out, 2, destination register.
  - RSrc1, out, 2, source register.
  - Src2, out, IMM_W, immediate.
  - state, out, 3, FSM state code.
  - halted, out, 1, HALT state indicator.
  - stack_err, out, 1, stack fault.
- REQ-003: Instruction fields SHALL be:
  - opcode = [INSTR_W-1:INSTR_W-3].
  - RDst3 = [IMM_W+4:IMM_W+3].
  - RSrc1 = [IMM_W+2:IMM_W+1].
  - ALUSrc2 = [IMM_W].
  - Src2 = [IMM_W-1:0].
  - cond = [IMM_W+4:IMM_W+1].

Function
- REQ-004: FSM states SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4, driven on state.
- REQ-005: IDLE SHALL go to FETCH with pc=RESET_PC when start=1; start SHALL be ignored in FETCH/DECODE/EXEC.
- REQ-006: FETCH SHALL hold instr_req=1 and InstrAddr=pc until instr_ack=1, then latch instr_rdata into IR and go to DECODE next cycle; wait length SHALL be unbounded.
- REQ-007: instr_ack outside FETCH SHALL be ignored; instr_req SHALL be 0 outside FETCH.
- REQ-008: DECODE SHALL last exactly one cycle and go to EXEC; EXEC SHALL last exactly one cycle, then go to FETCH (or HALT per REQ-012/REQ-015).
- REQ-009: RDst3, RSrc1, ALUSrc2 and Src2 SHALL reflect IR at all times.
- REQ-010: ALUCntr SHALL equal opcode for opcodes 000-101, else 000.
- REQ-011: Opcode handling:
  - 000-100: ALU op, ALUorM=0.
  - 101: load, ALUorM=1.
  - Both assert WE=1 in EXEC only; WE=0 otherwise.
- REQ-012: Opcode 110 is a conditional branch:
  - taken = cond[3] | (flagreg[cond[1:0]] ^ cond[2]).
  - Taken: pc ← Src2 resized to ADDR_W (truncate/zero-extend); not taken: pc ← pc+1.
- REQ-013: Opcode 111 is a system op selected by cond[1:0]: 00 HALT, 01 CALL, 10 RET, 11 NOP.
- REQ-014: flagreg SHALL capture ALUFlags at the EXEC cycle of opcodes 000-100 only, and hold otherwise.
- REQ-015: pc+1 SHALL wrap modulo 2^ADDR_W; HALT SHALL set halted=1 and stay until start=1, which goes to FETCH at RESET_PC with flagreg kept.

Reset
- REQ-016: While reset=0, regardless of state:
  - state=IDLE, pc=RESET_PC, IR=0, flagreg=0, stack empty.
  - instr_req, WE, halted, stack_err = 0.
  - Outputs SHALL change asynchronously, including mid-FETCH.
- REQ-017: The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
- REQ-018: Macro SEQ_CALL_STACK_EN:
  - Defined, CALL: pushes pc+1 and jumps to Src2.
  - Defined, RET: pops into pc.
  - Defined, fault: push when STACK_DEPTH entries are full, or pop when empty, SHALL go to HALT with stack_err=1 (sticky until reset) and leave the stack unchanged.
  - Undefined: CALL/RET SHALL act as NOP (pc ← pc+1), stack_err tied 0, no stack storage.

Verification
- REQ-019: Reset, start=1, instr_ack after 3 cycles -> InstrAddr=0 with instr_req=1 for 4 cycles; WE=1 exactly 2 cycles after ack for opcode 000.
- REQ-020: ALU op producing ALUFlags=0100, then branch cond=0001 (Z) target 0x40 -> next InstrAddr=0x40; with cond=0101 (inverted Z) -> next InstrAddr=pc+1.
- REQ-021: pc=0xFF, ADDR_W=8, ALU op -> next InstrAddr=0x00.
- REQ-022: HALT at 0x05 -> halted=1, instr_req=0 for 20 cycles; start=1 -> InstrAddr=RESET_PC.
- REQ-023: With SEQ_CALL_STACK_EN, STACK_DEPTH=4: five nested CALLs -> fifth gives HALT with stack_err=1; RET with stack empty -> HALT with stack_err=1.
- REQ-024: reset=0 asserted while instr_req=1 -> instr_req=0 and state=0 before the next clock edge.
